// File: rtl/hopfield_if.sv
// Command/status/debug bundle for hopfield_core: the pattern source is the master,
// the core is the slave.
interface hopfield_if #(
  parameter int N  = 25,
  parameter int WW = 4
);
  localparam int KW = $clog2(N);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [N-1:0]         cmd_pattern;
  logic [N-1:0]         neurons;
  logic                 busy;
  logic                 done;
  logic                 converged;
  logic [7:0]           sweeps;
  logic [KW-1:0]        rd_k;
  logic [KW-1:0]        rd_m;
  logic signed [WW-1:0] rd_w;

  modport master (
    output cmd_valid, cmd_op, cmd_pattern, rd_k, rd_m,
    input  cmd_ready, neurons, busy, done, converged, sweeps, rd_w
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_pattern, rd_k, rd_m,
    output cmd_ready, neurons, busy, done, converged, sweeps, rd_w
  );
endinterface

// File: rtl/hopfield_core.sv
// Hopfield associative memory: serial saturating Hebbian learn, sequential recall.
// Define HOPFIELD_ZERO_DIAG_EN to pin w[k][k] to zero and drop self-feedback from recall.
module hopfield_core #(
  parameter int N          = 25,
  parameter int WW         = 4,
  parameter int MAX_SWEEPS = 15
) (
  input  logic      clk,
  input  logic      rst,
  hopfield_if.slave bus
);
  localparam int WMAX = (1 << (WW-1)) - 1;
  localparam int SW   = $clog2(N*WMAX) + 2;
  localparam int KW   = $clog2(N);
  localparam int AW   = $clog2(N*N);

  typedef enum logic [2:0] {IDLE, CLEAR, LEARN, ACC, UPD, DONE} state_t;

  state_t               state;
  logic [KW-1:0]        k, m;
  logic [N-1:0]         pat;
  logic [N-1:0]         nrn;
  logic signed [SW-1:0] sum;
  logic                 changed;
  logic                 done_r, conv_r;
  logic [7:0]           swp;
  logic signed [WW-1:0] rdq;

  logic signed [WW-1:0] w [N*N];

  logic [AW-1:0]        waddr, raddr;
  logic signed [WW-1:0] wcur, wsat, wnext;
  logic signed [WW:0]   wext, wsum;
  logic signed [SW-1:0] term;
  logic                 last_m, last_k, same, nbit, chg_n, rd_ok;

  assign waddr  = AW'(k*N + m);
  assign raddr  = AW'(bus.rd_k*N + bus.rd_m);
  assign rd_ok  = ({1'b0, bus.rd_k} < (KW+1)'(N)) && ({1'b0, bus.rd_m} < (KW+1)'(N));
  assign wcur   = w[waddr];
  assign last_m = (m == KW'(N-1));
  assign last_k = (k == KW'(N-1));
  assign same   = (pat[k] == pat[m]);
  assign nbit   = (sum > 0);
  assign chg_n  = changed | (nbit != nrn[k]);

  // Learn in one extra bit so a stray out-of-range value after reset still clamps instead of wrapping.
  assign wext = (WW+1)'(wcur);
  assign wsum = same ? wext + (WW+1)'(1) : wext - (WW+1)'(1);

  always_comb begin
    wsat = wsum[WW-1:0];
    if (wsum > WMAX)       wsat = WW'(WMAX);
    else if (wsum < -WMAX) wsat = WW'(-WMAX);
  end

  always_comb begin
    wnext = (state == LEARN) ? wsat : '0;
`ifdef HOPFIELD_ZERO_DIAG_EN
    if (k == m) wnext = '0;
`endif
  end

  always_comb begin
    term = nrn[m] ? SW'(wcur) : -SW'(wcur);
`ifdef HOPFIELD_ZERO_DIAG_EN
    if (k == m) term = '0;
`endif
  end

  // Weight RAM is deliberately not reset; the read port sees pre-write data on a collision.
  always_ff @(posedge clk) begin
    if (rst && (state == CLEAR || state == LEARN)) w[waddr] <= wnext;
    rdq <= rd_ok ? w[raddr] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      k       <= '0;
      m       <= '0;
      pat     <= '0;
      nrn     <= '0;
      sum     <= '0;
      changed <= 1'b0;
      done_r  <= 1'b0;
      conv_r  <= 1'b0;
      swp     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid) begin
          conv_r <= 1'b0;
          k      <= '0;
          m      <= '0;
          pat    <= bus.cmd_pattern;
          case (bus.cmd_op)
            2'b00: state <= CLEAR;
            2'b01: state <= LEARN;
            2'b10: begin
              state   <= ACC;
              nrn     <= bus.cmd_pattern;
              swp     <= '0;
              changed <= 1'b0;
              sum     <= '0;
            end
            default: begin
              state  <= DONE;
              done_r <= 1'b1;
            end
          endcase
        end
        CLEAR, LEARN: begin
          if (last_m) begin
            m <= '0;
            k <= k + 1'b1;
          end else begin
            m <= m + 1'b1;
          end
          if (last_m && last_k) begin
            state  <= DONE;
            done_r <= 1'b1;
            conv_r <= 1'b1;
          end
        end
        ACC: begin
          sum <= sum + term;
          if (last_m) begin
            m     <= '0;
            state <= UPD;
          end else begin
            m <= m + 1'b1;
          end
        end
        UPD: begin
          nrn[k] <= nbit;
          sum    <= '0;
          if (!last_k) begin
            k       <= k + 1'b1;
            changed <= chg_n;
            state   <= ACC;
          end else begin
            swp     <= swp + 8'd1;
            k       <= '0;
            changed <= 1'b0;
            if (!chg_n) begin
              conv_r <= 1'b1;
              state  <= DONE;
              done_r <= 1'b1;
            end else if (swp + 8'd1 == 8'(MAX_SWEEPS)) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.converged = conv_r;
  assign bus.sweeps    = swp;
  assign bus.neurons   = nrn;
  assign bus.rd_w      = rdq;
endmodule

// File: tb/tb_hopfield_core.sv
// Randomized self-checking bench for hopfield_core against an array-based Hopfield model.
module tb_hopfield_core;
  localparam int N    = 25;
  localparam int WW   = 4;
  localparam int MAXS = 15;
  localparam int WMAX = 7;
  localparam int KW   = $clog2(N);
  localparam int SWP  = N*(N+1);
  localparam int TMO  = N*N + MAXS*SWP + 50;
`ifdef HOPFIELD_ZERO_DIAG_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif
  localparam logic [N-1:0] PD = 25'b0111010010100101001001111;
  localparam logic [N-1:0] PC = 25'b0011101001010000100011111;
  localparam logic [N-1:0] PJ = 25'b1111000001000010000111110;
  localparam logic [N-1:0] PM = 25'b1000110001101011101110001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hopfield_if #(.N(N), .WW(WW)) bus ();
  hopfield_core #(.N(N), .WW(WW), .MAX_SWEEPS(MAXS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nchk = 0;
  int nerr = 0;
  int bad_hs = 0;
  int mw [N][N];

  task automatic check(input string tag, input longint obs, input longint exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) mw[i][j] = 0;
  endfunction

  function automatic void m_learn(input logic [N-1:0] p);
    int v;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        v = mw[i][j] + ((p[i] == p[j]) ? 1 : -1);
        if (v > WMAX)  v = WMAX;
        if (v < -WMAX) v = -WMAX;
        if (ZD && i == j) v = 0;
        mw[i][j] = v;
      end
  endfunction

  function automatic void m_recall(input logic [N-1:0] p, output logic [N-1:0] s,
                                   output int sw, output bit cv);
    int acc, nchg;
    bit nb;
    s = p; sw = 0; cv = 1'b0;
    while (sw < MAXS) begin
      nchg = 0;
      for (int i = 0; i < N; i++) begin
        acc = 0;
        for (int j = 0; j < N; j++)
          if (!(ZD && i == j)) acc += s[j] ? mw[i][j] : -mw[i][j];
        nb = (acc > 0);
        if (nb != s[i]) nchg++;
        s[i] = nb;
      end
      sw++;
      if (nchg == 0) begin
        cv = 1'b1;
        break;
      end
    end
  endfunction

  task automatic run_cmd(input logic [1:0] op, input logic [N-1:0] p, input bit hold, output int lat);
    int g;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_pattern = p;
    g = 0;
    while (!bus.cmd_ready && g < TMO) begin
      @(negedge clk);
      g++;
    end
    if (g >= TMO) check("accept_timeout", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = hold; bus.cmd_op = 2'($urandom); bus.cmd_pattern = N'($urandom);
    lat = 0;
    while (!bus.done && lat < TMO) begin
      if (bus.cmd_ready || !bus.busy) bad_hs++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= TMO) check("done_timeout", bus.done, 1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic rd(input int k, input int m, output int v);
    @(negedge clk);
    bus.rd_k = KW'(k); bus.rd_m = KW'(m);
    @(posedge clk); #1;
    v = int'(bus.rd_w);
  endtask

  task automatic check_wmat(input string tag);
    int v, bad;
    bad = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        rd(i, j, v);
        if (v != mw[i][j]) bad++;
      end
    check(tag, bad, 0);
  endtask

  task automatic learn(input string tag, input logic [N-1:0] p);
    int lat;
    run_cmd(2'b01, p, 1'b0, lat);
    m_learn(p);
    check(tag, lat, N*N);
  endtask

  task automatic clear(input string tag);
    int lat;
    run_cmd(2'b00, '0, 1'b0, lat);
    m_clear();
    check(tag, lat, N*N);
  endtask

  task automatic recall_chk(input string tag, input logic [N-1:0] p);
    logic [N-1:0] es;
    int esw, lat;
    bit ecv;
    m_recall(p, es, esw, ecv);
    run_cmd(2'b10, p, 1'b0, lat);
    check({tag, "_neu"}, bus.neurons, es);
    check({tag, "_swp"}, bus.sweeps, esw);
    check({tag, "_cnv"}, bus.converged, ecv);
    check({tag, "_lat"}, lat, esw*SWP);
  endtask

  initial begin
    int v, lat;
    logic [N-1:0] pr, q, r1, r2;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_pattern = '0;
    bus.rd_k = '0; bus.rd_m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_neu", bus.neurons, 0);
    check("rst_done", bus.done, 0);
    check("rst_cnv", bus.converged, 0);
    check("rst_swp", bus.sweeps, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rdy", bus.cmd_ready, 1);
    @(negedge clk); rst = 1'b1;

    // abort a LEARN part-way with reset
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_pattern = PD;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("mid_busy", bus.busy, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("mrst_busy", bus.busy, 0);
    check("mrst_rdy", bus.cmd_ready, 1);
    check("mrst_done", bus.done, 0);
    @(negedge clk); rst = 1'b1;

    clear("clr_lat");
    check("clr_cnv", bus.converged, 1);
    @(posedge clk); #1;
    check("clr_pulse", bus.done, 0);
    check("clr_idle", bus.busy, 0);
    check_wmat("clr_wmat");

    learn("lrn1_lat", PD);
    check("lrn1_neu", bus.neurons, 0);
    rd(0, 1, v); check("w01", v, 1);
    rd(0, 5, v); check("w05", v, -1);
    rd(3, 3, v); check("w33", v, ZD ? 0 : 1);
    rd(N, 0, v); check("rd_oor_k", v, 0);
    rd(0, 31, v); check("rd_oor_m", v, 0);

    for (int i = 0; i < 9; i++) learn("lrnx_lat", PD);
    check_wmat("sat_wmat");
    rd(0, 1, v); check("sat_pos", v, 7);
    rd(0, 5, v); check("sat_neg", v, -7);

    clear("clr2_lat");
    learn("lrn2_lat", PD);
    recall_chk("rec_noisy", PD ^ 25'h0001001);
    check("rec_noisy_d", bus.neurons, PD);
    check("rec_noisy_s", bus.sweeps, 2);

    clear("clr3_lat");
    pr = bus.neurons;
    learn("lrnD", PD); learn("lrnC", PC); learn("lrnJ", PJ); learn("lrnM", PM);
    check("lrn_keep_neu", bus.neurons, pr);
    check_wmat("multi_wmat");
    recall_chk("recD", PD);
    recall_chk("recC", PC);
    recall_chk("recJ", PJ);
    recall_chk("recM", PM);
    check("rec_lim", bus.sweeps <= MAXS, 1);

    // zero weights, valid held high for the whole command
    clear("clr4_lat");
    run_cmd(2'b10, 25'h1FFFFFF, 1'b1, lat);
    check("ones_lat", lat, 2*SWP);
    check("ones_neu", bus.neurons, 0);
    check("ones_swp", bus.sweeps, 2);
    check("ones_cnv", bus.converged, 1);

    pr = bus.neurons;
    run_cmd(2'b11, PJ, 1'b0, lat);
    check("nop_lat", lat, 0);
    check("nop_neu", bus.neurons, pr);

    clear("clr5_lat");
    r1 = N'($urandom); r2 = N'($urandom);
    learn("lrnR1", r1); learn("lrnR2", r2);
    check_wmat("rnd_wmat");
    q = r1;
    q[$urandom_range(0, N-1)] ^= 1'b1;
    q[$urandom_range(0, N-1)] ^= 1'b1;
    recall_chk("recR1", q);
    recall_chk("recRnd", N'($urandom));

    check("hs_busy", bad_hs, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
